// File: rtl/block_memory_sequencer_if.sv
// Bundles the control handshakes and memory-side signals between the
// block memory sequencer and its surroundings.
interface block_memory_sequencer_if #(
    parameter int DATA_W = 48,
    parameter int HASH_W = 8,
    parameter int ADDR_W = 2
);
    logic              init_req;
    logic              load_req;
    logic              hash_phase;
    logic              write_phase;
    logic              done_mining;
    logic [DATA_W-1:0] init_data;
    logic [DATA_W-1:0] datapath_out;
    logic [HASH_W-1:0] mining_hash;

    logic              write_enable;
    logic              access_type;
    logic              load_registers;
    logic              load_previous_hash;
    logic              enable_mining;
    logic              done_hash_store;
    logic              done_memory_store;
    logic              finished_init;
    logic              chain_done;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] addr;

    modport master (
        input  init_req, load_req, hash_phase, write_phase, done_mining,
        input  init_data, datapath_out, mining_hash,
        output write_enable, access_type, load_registers, load_previous_hash,
        output enable_mining, done_hash_store, done_memory_store, finished_init,
        output chain_done, data_in, addr
    );

    modport slave (
        output init_req, load_req, hash_phase, write_phase, done_mining,
        output init_data, datapath_out, mining_hash,
        input  write_enable, access_type, load_registers, load_previous_hash,
        input  enable_mining, done_hash_store, done_memory_store, finished_init,
        input  chain_done, data_in, addr
    );
endinterface

// File: rtl/block_memory_sequencer.sv
// Walks a chain of memory blocks: one-shot initialisation, then per block a
// load, previous-hash fetch, mining window, hash write-back and data write-back.
module block_memory_sequencer #(
    parameter int DATA_W          = 48,
    parameter int HASH_W          = 8,
    parameter int NUM_BLOCKS      = 4,
    parameter int INIT_WAIT       = 15,
    parameter int ACCESS_WAIT     = 7,
    parameter int HASH_WRITE_WAIT = 1023
) (
    input logic                      clock,
    input logic                      reset,
    block_memory_sequencer_if.master bus
);

    localparam int ADDR_W   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int MAX_A    = (INIT_WAIT > ACCESS_WAIT) ? INIT_WAIT : ACCESS_WAIT;
    localparam int MAX_WAIT = (MAX_A > HASH_WRITE_WAIT) ? MAX_A : HASH_WRITE_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [CNT_W-1:0]  INIT_T   = CNT_W'(INIT_WAIT);
    localparam logic [CNT_W-1:0]  ACCESS_T = CNT_W'(ACCESS_WAIT);
    localparam logic [CNT_W-1:0]  HASH_T   = CNT_W'(HASH_WRITE_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(NUM_BLOCKS - 1);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_INIT_WRITE = 4'd1;
    localparam logic [3:0] S_INIT_DONE  = 4'd2;
    localparam logic [3:0] S_LOAD       = 4'd3;
    localparam logic [3:0] S_LOAD_WAIT  = 4'd4;
    localparam logic [3:0] S_WAIT_HASH  = 4'd5;
    localparam logic [3:0] S_GET_PREV   = 4'd6;
    localparam logic [3:0] S_MINE       = 4'd7;
    localparam logic [3:0] S_WRITE_HASH = 4'd8;
    localparam logic [3:0] S_WAIT_WRITE = 4'd9;
    localparam logic [3:0] S_WRITE_DATA = 4'd10;

    function automatic logic [ADDR_W-1:0] next_blk(input logic [ADDR_W-1:0] idx);
        if (idx == LAST_BLK) begin
            next_blk = {ADDR_W{1'b0}};
        end else begin
            next_blk = idx + ADDR_W'(1);
        end
    endfunction

    function automatic logic [ADDR_W-1:0] prev_blk(input logic [ADDR_W-1:0] idx);
        if (idx == {ADDR_W{1'b0}}) begin
            prev_blk = LAST_BLK;
        end else begin
            prev_blk = idx - ADDR_W'(1);
        end
    endfunction

    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] blk_idx_q, blk_idx_d;
    logic [ADDR_W-1:0] init_idx_q, init_idx_d;

    logic              write_enable_q, write_enable_d;
    logic              access_type_q, access_type_d;
    logic              load_registers_q, load_registers_d;
    logic              load_previous_hash_q, load_previous_hash_d;
    logic              enable_mining_q, enable_mining_d;
    logic              done_hash_store_q, done_hash_store_d;
    logic              done_memory_store_q, done_memory_store_d;
    logic              finished_init_q, finished_init_d;
    logic              chain_done_q, chain_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_in_s;

    // Next state, shared wait counter and block/init indices.
    always_comb begin
        state_d      = state_q;
        blk_idx_d    = blk_idx_q;
        init_idx_d   = init_idx_q;
        chain_done_d = 1'b0;
        // Saturate so idle-type states never wrap the counter.
        if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.init_req) begin
                    state_d    = S_INIT_WRITE;
                    init_idx_d = {ADDR_W{1'b0}};
                end else if (bus.load_req) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT_WRITE: begin
                if (cnt_q == INIT_T) begin
                    if (init_idx_q == LAST_BLK) begin
                        state_d    = S_INIT_DONE;
                        init_idx_d = {ADDR_W{1'b0}};
                    end else begin
                        init_idx_d = init_idx_q + ADDR_W'(1);
                        cnt_d      = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = S_INIT_WRITE;
                end
            end
            S_INIT_DONE: begin
                if (cnt_q == ACCESS_T) begin
                    state_d   = S_IDLE;
                    blk_idx_d = {ADDR_W{1'b0}};
                end else begin
                    state_d = S_INIT_DONE;
                end
            end
            S_LOAD: begin
                if (cnt_q == ACCESS_T) begin
                    state_d = S_LOAD_WAIT;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD_WAIT: begin
                if (cnt_q == ACCESS_T) begin
                    state_d = S_WAIT_HASH;
                end else begin
                    state_d = S_LOAD_WAIT;
                end
            end
            S_WAIT_HASH: begin
                if (bus.hash_phase) begin
                    state_d = S_GET_PREV;
                end else begin
                    state_d = S_WAIT_HASH;
                end
            end
            S_GET_PREV: begin
                if (cnt_q == ACCESS_T) begin
                    state_d = S_MINE;
                end else begin
                    state_d = S_GET_PREV;
                end
            end
            S_MINE: begin
                if (bus.done_mining) begin
                    state_d = S_WRITE_HASH;
                end else begin
                    state_d = S_MINE;
                end
            end
            S_WRITE_HASH: begin
                if (cnt_q == HASH_T) begin
                    state_d = S_WAIT_WRITE;
                end else begin
                    state_d = S_WRITE_HASH;
                end
            end
            S_WAIT_WRITE: begin
                if (bus.write_phase) begin
                    state_d = S_WRITE_DATA;
                end else begin
                    state_d = S_WAIT_WRITE;
                end
            end
            S_WRITE_DATA: begin
                if (cnt_q == ACCESS_T) begin
                    state_d      = S_IDLE;
                    blk_idx_d    = next_blk(blk_idx_q);
                    chain_done_d = (blk_idx_q == LAST_BLK);
                end else begin
                    state_d = S_WRITE_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Output decode from the upcoming state so the flops present it in step with state_q.
    always_comb begin
        write_enable_d       = 1'b0;
        access_type_d        = 1'b0;
        load_registers_d     = 1'b0;
        load_previous_hash_d = 1'b0;
        enable_mining_d      = 1'b0;
        done_hash_store_d    = 1'b0;
        done_memory_store_d  = 1'b0;
        finished_init_d      = 1'b0;
        addr_d               = blk_idx_d;
        case (state_d)
            S_IDLE:       done_memory_store_d = 1'b1;
            S_INIT_WRITE: begin
                write_enable_d = 1'b1;
                addr_d         = init_idx_d;
            end
            S_INIT_DONE:  finished_init_d = 1'b1;
            S_LOAD:       addr_d = blk_idx_d;
            S_LOAD_WAIT:  load_registers_d = 1'b1;
            S_WAIT_HASH:  addr_d = blk_idx_d;
            S_GET_PREV: begin
                access_type_d        = 1'b1;
                load_previous_hash_d = 1'b1;
                addr_d               = prev_blk(blk_idx_d);
            end
            S_MINE: begin
                enable_mining_d = 1'b1;
                access_type_d   = 1'b1;
            end
            S_WRITE_HASH: begin
                write_enable_d = 1'b1;
                access_type_d  = 1'b1;
            end
            S_WAIT_WRITE: done_hash_store_d = 1'b1;
            S_WRITE_DATA: write_enable_d = 1'b1;
            default:      done_memory_store_d = 1'b1;
        endcase
    end

    // Write data source follows the current state; everything else is registered.
    always_comb begin
        case (state_q)
            S_INIT_WRITE: data_in_s = bus.init_data;
            S_WRITE_HASH: data_in_s = DATA_W'(bus.mining_hash);
            default:      data_in_s = bus.datapath_out;
        endcase
    end

    // State, counter, indices and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q              <= S_IDLE;
            cnt_q                <= {CNT_W{1'b0}};
            blk_idx_q            <= {ADDR_W{1'b0}};
            init_idx_q           <= {ADDR_W{1'b0}};
            write_enable_q       <= 1'b0;
            access_type_q        <= 1'b0;
            load_registers_q     <= 1'b0;
            load_previous_hash_q <= 1'b0;
            enable_mining_q      <= 1'b0;
            done_hash_store_q    <= 1'b0;
            done_memory_store_q  <= 1'b1;
            finished_init_q      <= 1'b0;
            chain_done_q         <= 1'b0;
            addr_q               <= {ADDR_W{1'b0}};
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            blk_idx_q            <= blk_idx_d;
            init_idx_q           <= init_idx_d;
            write_enable_q       <= write_enable_d;
            access_type_q        <= access_type_d;
            load_registers_q     <= load_registers_d;
            load_previous_hash_q <= load_previous_hash_d;
            enable_mining_q      <= enable_mining_d;
            done_hash_store_q    <= done_hash_store_d;
            done_memory_store_q  <= done_memory_store_d;
            finished_init_q      <= finished_init_d;
            chain_done_q         <= chain_done_d;
            addr_q               <= addr_d;
        end
    end

    assign bus.write_enable       = write_enable_q;
    assign bus.access_type        = access_type_q;
    assign bus.load_registers     = load_registers_q;
    assign bus.load_previous_hash = load_previous_hash_q;
    assign bus.enable_mining      = enable_mining_q;
    assign bus.done_hash_store    = done_hash_store_q;
    assign bus.done_memory_store  = done_memory_store_q;
    assign bus.finished_init      = finished_init_q;
    assign bus.chain_done         = chain_done_q;
    assign bus.addr               = addr_q;
    assign bus.data_in            = data_in_s;

endmodule

// File: tb/tb_block_memory_sequencer.sv
// Randomised bench: a phase-level model of the block walk predicts every
// output cycle; literal counts pin the init, hash-write and wrap behaviour.
module tb_block_memory_sequencer;
    localparam int DW = 48;
    localparam int HW = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    localparam int K_IDLE = 0, K_INITW = 1, K_INITD = 2, K_LOAD = 3, K_LOADW = 4;
    localparam int K_WHASH = 5, K_GETP = 6, K_MINE = 7, K_WRH = 8, K_WWRITE = 9, K_WRD = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    block_memory_sequencer_if #(.DATA_W(DW), .HASH_W(HW), .ADDR_W(AW)) bus ();

    block_memory_sequencer #(
        .DATA_W(DW), .HASH_W(HW), .NUM_BLOCKS(N),
        .INIT_WAIT(15), .ACCESS_WAIT(7), .HASH_WRITE_WAIT(1023)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;
    int exp_kind = K_IDLE;
    int exp_addr = 0;
    logic exp_cd = 1'b0;
    int m_blk = 0;
    bit m_chain = 1'b0;

    int we_cnt = 0, fin_cnt = 0, lr_cnt = 0, wh_cnt = 0, cd_cnt = 0;
    int lph_addr = -1, idle_addr = -1;
    logic [8:0] ef, af;
    logic [DW-1:0] ed;

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the phase the model says we are in.
    always @(negedge clock) begin
        if (chk_en) begin
            ef = 9'b0;
            ed = bus.datapath_out;
            case (exp_kind)
                K_IDLE:   begin ef[2] = 1'b1; ef[0] = exp_cd; end
                K_INITW:  begin ef[8] = 1'b1; ed = bus.init_data; end
                K_INITD:  ef[1] = 1'b1;
                K_LOADW:  ef[6] = 1'b1;
                K_GETP:   begin ef[7] = 1'b1; ef[5] = 1'b1; end
                K_MINE:   begin ef[7] = 1'b1; ef[4] = 1'b1; end
                K_WRH:    begin ef[8] = 1'b1; ef[7] = 1'b1; ed = {{(DW-HW){1'b0}}, bus.mining_hash}; end
                K_WWRITE: ef[3] = 1'b1;
                K_WRD:    ef[8] = 1'b1;
                default:  ef = 9'b0;
            endcase
            af = {bus.write_enable, bus.access_type, bus.load_registers, bus.load_previous_hash,
                  bus.enable_mining, bus.done_hash_store, bus.done_memory_store,
                  bus.finished_init, bus.chain_done};
            check("flags{we,at,lr,lph,em,dhs,dms,fin,cd}", longint'(af), longint'(ef));
            check("addr", longint'(bus.addr), longint'(exp_addr));
            check("data_in", longint'(bus.data_in), longint'(ed));
            if (bus.write_enable) we_cnt++;
            if (bus.finished_init) fin_cnt++;
            if (bus.load_registers) lr_cnt++;
            if (bus.write_enable && bus.access_type) wh_cnt++;
            if (bus.chain_done) cd_cnt++;
            if (bus.load_previous_hash) lph_addr = int'(bus.addr);
            if (bus.done_memory_store) idle_addr = int'(bus.addr);
        end
    end

    // One cycle in phase k: controls that matter there come from ctl, the rest is noise.
    task automatic cyc(input int k, input int a, input logic [1:0] ctl, input logic r);
        exp_kind = k;
        exp_addr = a;
        exp_cd   = (k == K_IDLE) ? m_chain : 1'b0;
        if (k == K_IDLE) m_chain = 1'b0;
        reset            = r;
        bus.init_data    = DW'({$urandom, $urandom});
        bus.datapath_out = DW'({$urandom, $urandom});
        bus.mining_hash  = HW'($urandom);
        bus.init_req     = (k == K_IDLE)   ? ctl[1] : 1'($urandom_range(0, 1));
        bus.load_req     = (k == K_IDLE)   ? ctl[0] : 1'($urandom_range(0, 1));
        bus.hash_phase   = (k == K_WHASH)  ? ctl[0] : 1'($urandom_range(0, 1));
        bus.done_mining  = (k == K_MINE)   ? ctl[0] : 1'($urandom_range(0, 1));
        bus.write_phase  = (k == K_WWRITE) ? ctl[0] : 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(K_IDLE, m_blk, 2'b00, 1'b0);
    endtask

    task automatic do_pass(input int mine_n, input int rst_at);
        int prev;
        prev = (m_blk + N - 1) % N;
        cyc(K_IDLE, m_blk, 2'b01, 1'b0);
        repeat (8) cyc(K_LOAD, m_blk, 2'b00, 1'b0);
        repeat (8) cyc(K_LOADW, m_blk, 2'b00, 1'b0);
        repeat ($urandom_range(0, 3)) cyc(K_WHASH, m_blk, 2'b00, 1'b0);
        cyc(K_WHASH, m_blk, 2'b01, 1'b0);
        repeat (8) cyc(K_GETP, prev, 2'b00, 1'b0);
        repeat (mine_n) cyc(K_MINE, m_blk, 2'b00, 1'b0);
        cyc(K_MINE, m_blk, 2'b01, 1'b0);
        for (int i = 0; i < 1024; i++) begin
            if (i == rst_at) begin
                cyc(K_WRH, m_blk, 2'b00, 1'b1);
                m_blk   = 0;
                m_chain = 1'b0;
                return;
            end
            cyc(K_WRH, m_blk, 2'b00, 1'b0);
        end
        repeat ($urandom_range(0, 3)) cyc(K_WWRITE, m_blk, 2'b00, 1'b0);
        cyc(K_WWRITE, m_blk, 2'b01, 1'b0);
        repeat (8) cyc(K_WRD, m_blk, 2'b00, 1'b0);
        m_chain = (m_blk == N - 1);
        m_blk   = (m_blk + 1) % N;
    endtask

    initial begin
        int s_we, s_fin, s_lr, s_wh, s_cd;
        bus.init_req = 1'b0; bus.load_req = 1'b0; bus.hash_phase = 1'b0;
        bus.write_phase = 1'b0; bus.done_mining = 1'b0;
        bus.init_data = '0; bus.datapath_out = '0; bus.mining_hash = '0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk_en = 1'b1;
        repeat (2) cyc(K_IDLE, 0, 2'b00, 1'b1);
        idle(2);

        // Init with a simultaneous load request: init must win.
        s_we = we_cnt; s_fin = fin_cnt; s_lr = lr_cnt;
        cyc(K_IDLE, m_blk, 2'b11, 1'b0);
        for (int a = 0; a < N; a++) repeat (16) cyc(K_INITW, a, 2'b00, 1'b0);
        repeat (8) cyc(K_INITD, m_blk, 2'b00, 1'b0);
        m_blk = 0;
        idle(2);
        check("init_write_cycles", we_cnt - s_we, 64);
        check("init_finished_cycles", fin_cnt - s_fin, 8);
        check("load_not_entered", lr_cnt - s_lr, 0);

        do_pass(4, -1);
        check("prev_addr_blk0", lph_addr, 3);
        idle($urandom_range(0, 3));
        do_pass($urandom_range(0, 6), -1);
        check("prev_addr_blk1", lph_addr, 0);

        s_wh = wh_cnt;
        do_pass(5, -1);
        check("hash_write_cycles", wh_cnt - s_wh, 1024);
        check("prev_addr_blk2", lph_addr, 1);
        idle(1);
        check("blk_after_pass2", idle_addr, 3);

        s_cd = cd_cnt;
        do_pass(3, -1);
        check("prev_addr_blk3", lph_addr, 2);
        idle(3);
        check("chain_done_pulses", cd_cnt - s_cd, 1);
        check("blk_after_wrap", idle_addr, 0);

        do_pass(2, -1);
        idle(1);
        check("blk_before_reset", idle_addr, 1);
        s_we = we_cnt;
        do_pass(2, 500);
        idle(2);
        check("blk_after_reset", idle_addr, 0);
        check("no_write_after_reset", we_cnt - s_we, 501);

        do_pass(1, -1);
        idle(2);
        check("blk_after_recovery", idle_addr, 1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/block_memory_sequencer.md
BLOCK_MEMORY_SEQUENCER -- requirements
Module: block_memory_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 48: data word width.
REQ-002 SHALL have parameter HASH_W, default 8: hash width, with HASH_W <= DATA_W.
REQ-003 SHALL have parameter NUM_BLOCKS, default 4: blocks in the chain, at least 1; ADDR_W = max(1, clog2(NUM_BLOCKS)).
REQ-004 SHALL have parameters INIT_WAIT 15, ACCESS_WAIT 7, HASH_WRITE_WAIT 1023: terminal counts of the wait counter.
REQ-005 SHALL have ports clock (in, 1) and reset (in, 1); one clock, reset synchronous active-high.
REQ-006 SHALL have inputs init_req, load_req, hash_phase, write_phase, done_mining (1 bit each).
REQ-007 SHALL have inputs init_data [DATA_W], datapath_out [DATA_W] and mining_hash [HASH_W].
REQ-008 SHALL have 1-bit outputs write_enable, access_type (0 = data region, 1 = hash region), load_registers, load_previous_hash and enable_mining.
REQ-009 SHALL have 1-bit outputs done_hash_store, done_memory_store, finished_init and chain_done.
REQ-010 SHALL have outputs data_in [DATA_W] and addr [ADDR_W].

Function
REQ-011 SHALL implement the states IDLE, INIT_WRITE, INIT_DONE, LOAD, LOAD_WAIT, WAIT_HASH, GET_PREV, MINE, WRITE_HASH, WAIT_WRITE and WRITE_DATA.
REQ-012 SHALL use one shared wait counter, cleared on every state change and incremented each cycle otherwise.
REQ-013 SHALL make a timed state exit when the counter equals its terminal T, so a timed state lasts T+1 cycles.
REQ-014 SHALL, in IDLE, go to INIT_WRITE on init_req (init_req wins over load_req), else to LOAD on load_req, else stay.
REQ-015 SHALL, in INIT_WRITE, drive write_enable=1, access_type=0, data_in=init_data, addr=init_idx.
REQ-016 SHALL, in INIT_WRITE, hold each address INIT_WAIT+1 cycles, then increment init_idx and clear the counter.
REQ-017 SHALL, in INIT_WRITE, go to INIT_DONE after address NUM_BLOCKS-1 completes.
REQ-018 SHALL, in INIT_DONE, drive finished_init=1 for ACCESS_WAIT+1 cycles, then go to IDLE with blk_idx=0.
REQ-019 SHALL, in LOAD, read data at addr=blk_idx for ACCESS_WAIT+1 cycles, then go to LOAD_WAIT.
REQ-020 SHALL, in LOAD_WAIT, drive load_registers=1 for ACCESS_WAIT+1 cycles, then go to WAIT_HASH.
REQ-021 SHALL, in WAIT_HASH, go to GET_PREV when hash_phase=1.
REQ-022 SHALL, in GET_PREV, drive access_type=1 and load_previous_hash=1 for ACCESS_WAIT+1 cycles.
REQ-023 SHALL, in GET_PREV, read addr = blk_idx-1 modulo NUM_BLOCKS.
REQ-024 SHALL, in MINE, drive enable_mining=1 and access_type=1, and go to WRITE_HASH on done_mining.
REQ-025 SHALL, in WRITE_HASH, drive write_enable=1, access_type=1, addr=blk_idx and data_in = zero-extended mining_hash for HASH_WRITE_WAIT+1 cycles.
REQ-026 SHALL, in WAIT_WRITE, drive done_hash_store=1 and go to WRITE_DATA when write_phase=1.
REQ-027 SHALL, in WRITE_DATA, drive write_enable=1, access_type=0, data_in=datapath_out, addr=blk_idx for ACCESS_WAIT+1 cycles.
REQ-028 SHALL, on leaving WRITE_DATA, return to IDLE and increment blk_idx.
REQ-029 SHALL, when blk_idx wraps from NUM_BLOCKS-1 to 0, pulse chain_done for one cycle.
REQ-030 SHALL, in IDLE, drive done_memory_store=1, data_in=datapath_out, addr=blk_idx.
REQ-031 SHALL drive every output not named for a state to 0, with data_in=datapath_out and addr=blk_idx.
REQ-032 SHALL ignore init_req and load_req outside IDLE.
REQ-033 SHALL ignore done_mining outside MINE.
REQ-034 SHALL size the counter to hold the largest terminal and never let it wrap inside a state.
REQ-035 SHALL make all outputs pure functions of state and registers, except data_in, which passes through the selected input.

Reset
REQ-036 SHALL, on reset=1 at a clock edge, force the state to IDLE and clear the counter, blk_idx and init_idx, from any state including mid-write.
REQ-037 SHALL, during and after reset, present IDLE outputs: done_memory_store=1, all other 1-bit outputs 0, addr=0.

Verification
REQ-038 SHALL test: NUM_BLOCKS=4, init_req pulse -> write_enable high 64 cycles on addr 0,1,2,3 (16 cycles each), then finished_init high 8 cycles, then IDLE.
REQ-039 SHALL test: init_req and load_req together in IDLE -> INIT_WRITE entered, LOAD not entered.
REQ-040 SHALL test: full pass on blk_idx=2 with done_mining after 5 MINE cycles -> GET_PREV reads addr 1; hash write lasts 1024 cycles; WRITE_DATA writes addr 2; blk_idx becomes 3.
REQ-041 SHALL test: full pass at blk_idx=3 -> GET_PREV reads addr 2; chain_done pulses 1 cycle; blk_idx becomes 0.
REQ-042 SHALL test: blk_idx=0 -> GET_PREV reads addr 3; done_mining pulsed while in WAIT_HASH -> ignored, MINE still waits.
REQ-043 SHALL test: reset asserted at WRITE_HASH cycle 500 -> IDLE the next cycle, write_enable=0, blk_idx=0.
